// File: rtl/alu_issue_stage_if.sv
// Interfaces around the ALU issue stage: the upstream issue bus (instruction,
// register reads, forwarding and flush) and the downstream operation bus to the ALU.
interface issue_in_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            exmem_we;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_data;
    logic            memwb_we;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_data;
    logic            flush;

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
               exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data, flush,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data,
               exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data, flush,
        output in_ready
    );
endinterface

interface alu_op_if #(
    parameter int XLEN = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [3:0]      out_alu_ctrl;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            out_illegal;

    modport master (
        output out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_reg_write, out_illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_reg_write, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I issue stage: decodes the ALU control code, forwards and selects operands,
// and holds the result in a one-entry valid/ready register feeding the ALU.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    issue_in_if.slave up,
    alu_op_if.master  alu
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctrl_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic alu_ctrl_e funct3_map(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // x0 never forwards; EX/MEM is younger than MEM/WB so it wins.
    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_we,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (src == 5'd0)                  return '0;
        else if (ex_we && (ex_rd == src)) return ex_data;
        else if (wb_we && (wb_rd == src)) return wb_data;
        else                              return rf_data;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    alu_ctrl_e       w_ctrl;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_reg_write;
    logic            w_illegal;
    logic            w_in_ready;
    logic            w_capture;

    logic            r_valid;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    alu_ctrl_e       r_ctrl;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_illegal;

    assign w_opcode = up.in_instr[6:0];
    assign w_funct3 = up.in_instr[14:12];
    assign w_funct7 = up.in_instr[31:25];
    assign w_rs1    = up.in_instr[19:15];
    assign w_rs2    = up.in_instr[24:20];
    assign w_rd     = up.in_instr[11:7];

    assign w_imm_i  = XLEN'($signed(up.in_instr[31:20]));
    assign w_imm_s  = XLEN'($signed({up.in_instr[31:25], up.in_instr[11:7]}));
    assign w_imm_u  = XLEN'($signed({up.in_instr[31:12], 12'b0}));
    assign w_shamt  = XLEN'(up.in_instr[24:20]);

    assign w_rs1_val = forward(w_rs1, up.in_rs1_data, up.exmem_we, up.exmem_rd, up.exmem_data,
                               up.memwb_we, up.memwb_rd, up.memwb_data);
    assign w_rs2_val = forward(w_rs2, up.in_rs2_data, up.exmem_we, up.exmem_rd, up.exmem_data,
                               up.memwb_we, up.memwb_rd, up.memwb_data);

    always_comb begin
        w_ctrl      = ALU_ADD;
        w_a         = w_rs1_val;
        w_b         = w_rs2_val;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_reg_write = 1'b1;
                if (w_funct7 == F7_BASE)                          w_ctrl = funct3_map(w_funct3);
                else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) w_ctrl = ALU_SUB;
                else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) w_ctrl = ALU_SRA;
                else                                              w_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                w_reg_write = 1'b1;
                w_ctrl      = funct3_map(w_funct3);
                w_b         = w_imm_i;
                if (w_funct3 == 3'b001) begin
                    w_b = w_shamt;
                    if (w_funct7 != F7_BASE) w_illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    w_b = w_shamt;
                    if (w_funct7 == F7_ALT)       w_ctrl = ALU_SRA;
                    else if (w_funct7 != F7_BASE) w_illegal = 1'b1;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                w_reg_write = 1'b1;
                w_b         = w_imm_i;
            end
            OPC_STORE: begin
                w_b = w_imm_s;
            end
            OPC_BRANCH: begin
                case (w_funct3)
                    3'b000, 3'b001: w_ctrl = ALU_SUB;
                    3'b100, 3'b101: w_ctrl = ALU_SLT;
                    3'b110, 3'b111: w_ctrl = ALU_SLTU;
                    default:        w_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_reg_write = 1'b1;
                w_a         = '0;
                w_b         = w_imm_u;
            end
            OPC_AUIPC: begin
                w_reg_write = 1'b1;
                w_a         = up.in_pc;
                w_b         = w_imm_u;
            end
            OPC_JAL: begin
                w_reg_write = 1'b1;
                w_a         = up.in_pc;
                w_b         = XLEN'(4);
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_ctrl      = ALU_AND;
            w_reg_write = 1'b0;
        end
        if (w_rd == 5'd0) w_reg_write = 1'b0;
    end

    assign w_in_ready = !r_valid || alu.out_ready;
    assign w_capture  = up.in_valid && w_in_ready;

    // Flush beats capture and hold; on a flush the data fields may stay stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_ctrl      <= ALU_AND;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (up.flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_a         <= w_a;
            r_b         <= w_b;
            r_ctrl      <= w_ctrl;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_illegal   <= w_illegal;
        end else if (alu.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign up.in_ready       = w_in_ready;
    assign alu.out_valid     = r_valid;
    assign alu.out_a         = r_a;
    assign alu.out_b         = r_b;
    assign alu.out_alu_ctrl  = r_ctrl;
    assign alu.out_rd        = r_rd;
    assign alu.out_reg_write = r_reg_write;
    assign alu.out_illegal   = r_illegal;

endmodule
